// File: rtl/mc_core_irq.sv
// Multicycle MIPS core: datapath plus control FSM on one shared memory port,
// with wait-state handshake, vectored interrupt entry / eret and an illegal-opcode flag.
module mc_core_irq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'hFFFF_FFFC,
  parameter bit          IRQ_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        irq,
  output logic        irq_ack,
  output logic        illegal,
  output logic [31:0] pc
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    ADDIEX, ADDIWB, BRANCH, JUMP, ERET, IRQ
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_J = 6'h02, OP_ERET = 6'h10;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A, FN_ERET = 6'h18;

  state_t      state;
  logic [31:0] pcReg, ir, aReg, bReg, aluOut, mdr, epc;
  logic        ie, fetchWait;
  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, rsVal, rtVal, aluRes, rfWd;
  logic [4:0]  rfWa;
  logic        takeIrq, functOk, rfWe;
  logic        unusedShamt;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign unusedShamt = ^ir[10:6];
  assign simm        = {{16{ir[15]}}, ir[15:0]};
  assign rsVal       = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign rtVal       = (rt == 5'd0) ? 32'h0 : regs[rt];
  assign functOk     = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

  // irq is only looked at before the fetch has started waiting
  assign takeIrq   = IRQ_EN && irq && ie && (state == FETCH) && !fetchWait;
  assign mem_req   = rst_n && (((state == FETCH) && !takeIrq) || (state == MEMRD) || (state == MEMWR));
  assign mem_we    = rst_n && (state == MEMWR);
  assign mem_addr  = (state == FETCH) ? pcReg : aluOut;
  assign mem_wdata = bReg;
  assign pc        = pcReg;

  always_comb begin
    case (funct)
      FN_ADD:  aluRes = aReg + bReg;
      FN_SUB:  aluRes = aReg - bReg;
      FN_AND:  aluRes = aReg & bReg;
      FN_OR:   aluRes = aReg | bReg;
      FN_SLT:  aluRes = {31'h0, $signed(aReg) < $signed(bReg)};
      default: aluRes = 32'h0;
    endcase
  end

  always_comb begin
    rfWe = 1'b0;
    rfWa = rt;
    rfWd = aluOut;
    case (state)
      MEMWB:   begin rfWe = 1'b1; rfWd = mdr; end
      ALUWB:   begin rfWe = 1'b1; rfWa = rd; end
      ADDIWB:  rfWe = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk)
    if (rst_n && rfWe && rfWa != 5'd0) regs[rfWa] <= rfWd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pcReg     <= RESET_PC;
      ir        <= 32'h0;
      aReg      <= 32'h0;
      bReg      <= 32'h0;
      aluOut    <= 32'h0;
      mdr       <= 32'h0;
      epc       <= 32'h0;
      ie        <= 1'b1;
      fetchWait <= 1'b0;
      irq_ack   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      irq_ack <= 1'b0;
      illegal <= 1'b0;
      case (state)
        FETCH: begin
          if (takeIrq) begin
            state   <= IRQ;
            irq_ack <= 1'b1;
          end else if (mem_ready) begin
            ir        <= mem_rdata;
            pcReg     <= pcReg + 32'd4;
            fetchWait <= 1'b0;
            state     <= DECODE;
          end else begin
            fetchWait <= 1'b1;
          end
        end
        DECODE: begin
          aReg   <= rsVal;
          bReg   <= rtVal;
          aluOut <= pcReg + (simm << 2);
          case (op)
            OP_R:         if (functOk) state <= EXEC;
                          else begin illegal <= 1'b1; state <= FETCH; end
            OP_LW, OP_SW: state <= MEMADR;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            OP_ERET:      if (funct == FN_ERET) state <= ERET;
                          else begin illegal <= 1'b1; state <= FETCH; end
            default:      begin illegal <= 1'b1; state <= FETCH; end
          endcase
        end
        MEMADR: begin
          aluOut <= aReg + simm;
          state  <= (op == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= MEMWB;
        end
        MEMWR:  if (mem_ready) state <= FETCH;
        EXEC: begin
          aluOut <= aluRes;
          state  <= ALUWB;
        end
        ADDIEX: begin
          aluOut <= aReg + simm;
          state  <= ADDIWB;
        end
        BRANCH: begin
          if (aReg == bReg) pcReg <= aluOut;
          state <= FETCH;
        end
        JUMP: begin
          pcReg <= {pcReg[31:28], ir[25:0], 2'b00};
          state <= FETCH;
        end
        ERET: begin
          pcReg <= epc;
          ie    <= 1'b1;
          state <= FETCH;
        end
        IRQ: begin
          epc   <= pcReg;
          pcReg <= INT_VECTOR;
          ie    <= 1'b0;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_core_irq.sv
// Bench for mc_core_irq: ISA-level model predicts every memory access; directed
// programs cover ALU ops, wait states, interrupts, illegal opcodes and mid-access reset.
module tb_mc_core_irq;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] VEC    = 32'hFFFF_FFFC;

  logic        clk = 1'b0, rst_n = 1'b0, irq = 1'b0;
  logic [31:0] memAddr, memWdata, memRdata, pcOut;
  logic        memReq, memWe, memReady, irqAck, illegal;

  always #5 clk = ~clk;

  mc_core_irq #(.RESET_PC(RST_PC), .INT_VECTOR(VEC), .IRQ_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_req(memReq), .mem_we(memWe), .mem_ready(memReady), .mem_rdata(memRdata),
    .irq(irq), .irq_ack(irqAck), .illegal(illegal), .pc(pcOut)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        fetch;
  } acc_t;

  int nVec = 0, nErr = 0, cyc = 0, hit10 = 0;
  int waitStates = 0, waitCnt = 0;
  int actAck = 0, actIll = 0, expAck = 0, expIll = 0;
  logic [31:0] mem [256];
  logic [31:0] mMem [256];
  logic [31:0] mRegs [32];
  logic [31:0] mPc = RST_PC, mEpc = 32'h0;
  bit          mIe = 1'b1;
  acc_t        expQ [$];
  logic [31:0] irqAt [$];
  logic [31:0] logAddr [$];
  int          logCyc [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] encI(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] encR(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] encJ(logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic put(logic [31:0] a, logic [31:0] d);
    mem[a[9:2]]  = d;
    mMem[a[9:2]] = d;
  endtask

  // One architectural step: an interrupt entry or one whole instruction.
  function automatic void modelStep();
    logic [31:0] ins, npc, simm, a, b, r, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, wa;
    bit          wr;
    if (irqAt.size() > 0 && mIe && mPc == irqAt[0]) begin
      void'(irqAt.pop_front());
      mEpc = mPc; mPc = VEC; mIe = 1'b0; expAck++;
      return;
    end
    ins = mMem[mPc[9:2]];
    expQ.push_back('{mPc, 1'b0, 32'h0, 1'b1});
    npc = mPc + 32'd4;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    a = (rs == 0) ? 32'h0 : mRegs[rs];
    b = (rt == 0) ? 32'h0 : mRegs[rt];
    ea = a + simm;
    wr = 1'b0; wa = rt; r = 32'h0;
    case (op)
      6'h00: begin
        wr = 1'b1; wa = rd;
        case (fn)
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; expIll++; end
        endcase
      end
      6'h23: begin expQ.push_back('{ea, 1'b0, 32'h0, 1'b0}); r = mMem[ea[9:2]]; wr = 1'b1; end
      6'h2B: begin expQ.push_back('{ea, 1'b1, b, 1'b0}); mMem[ea[9:2]] = b; end
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h08: begin r = ea; wr = 1'b1; end
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h10: if (fn == 6'h18) begin npc = mEpc; mIe = 1'b1; end else expIll++;
      default: expIll++;
    endcase
    if (wr && wa != 0) mRegs[wa] = r;
    mPc = npc;
  endfunction

  function automatic int lat(logic [31:0] a);
    for (int i = 0; i + 1 < logAddr.size(); i++)
      if (logAddr[i] == a) return logCyc[i+1] - logCyc[i];
    return -1;
  endfunction

  function automatic logic [31:0] fetchAfter(logic [31:0] a, int k);
    for (int i = 0; i + k < logAddr.size(); i++)
      if (logAddr[i] == a) return logAddr[i+k];
    return 32'hBAD0_BAD0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: waitStates low-ready cycles per access, writes commit on handshake.
  initial begin : responder
    bit          hs = 1'b0, weL = 1'b0;
    logic [31:0] addrL = 0, wdL = 0;
    memReady = 1'b0;
    memRdata = 32'h0;
    forever begin
      @(posedge clk);
      if (hs) begin
        if (weL) mem[addrL[9:2]] = wdL;
        waitCnt = 0;
      end
      #3;
      hs = 1'b0;
      memReady = 1'b0;
      if (!memReq) waitCnt = 0;
      else if (waitCnt < waitStates) waitCnt++;
      else begin
        memReady = 1'b1;
        memRdata = mem[memAddr[9:2]];
        hs = 1'b1; addrL = memAddr; weL = memWe; wdL = memWdata;
      end
    end
  end

  // Compare process: every completed access is checked against the model.
  initial begin : compare
    acc_t e;
    forever begin
      @(negedge clk);
      if (irqAck) actAck++;
      if (illegal) actIll++;
      if (!rst_n) begin
        check("req_in_reset", {31'h0, memReq}, 32'h0);
        mPc = RST_PC; mIe = 1'b1; mEpc = 32'h0;
        expQ.delete(); logAddr.delete(); logCyc.delete(); hit10 = 0;
      end else if (memReq && memReady) begin
        for (int g = 0; g < 4 && expQ.size() == 0; g++) modelStep();
        if (expQ.size() == 0) begin
          nVec++; nErr++;
          $display("FAIL model_empty: got access at %h want none (cycle %0d)", memAddr, cyc);
        end else begin
          e = expQ.pop_front();
          check("acc_addr", memAddr, e.addr);
          check("acc_we", {31'h0, memWe}, {31'h0, e.we});
          if (e.we) check("acc_wdata", memWdata, e.wdata);
          if (e.fetch) begin
            check("fetch_pc", pcOut, e.addr);
            logAddr.push_back(memAddr);
            logCyc.push_back(cyc);
            if (memAddr == 32'h10) hit10++;
          end
        end
      end
    end
  end

  task automatic startPhase(int ws);
    @(posedge clk); #1;
    rst_n = 1'b0; irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    waitStates = ws;
    actAck = 0; actIll = 0; expAck = 0; expIll = 0;
    irqAt.delete();
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; mMem[i] = 32'h0; end
  endtask

  task automatic releaseRst();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_req", {31'h0, memReq}, 32'h1);
    check("rst_addr", memAddr, RST_PC);
    check("rst_pc", pcOut, RST_PC);
    check("rst_ack", {30'h0, irqAck, illegal}, 32'h0);
  endtask

  task automatic waitLoop(string name);
    int n = 0;
    while (hit10 < 2 && n < 400) begin @(posedge clk); n++; end
    check(name, {31'h0, hit10 >= 2}, 32'h1);
  endtask

  initial begin : stim
    int n;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;

    // ALU ops, $0 write, immediates, jump and branch, zero wait
    startPhase(0);
    put(32'h100, encI(6'h08, 0, 1, 16'd5));
    put(32'h104, encI(6'h2B, 0, 1, 16'h80));
    put(32'h108, encR(1, 1, 0, 6'h20));
    put(32'h10C, encI(6'h2B, 0, 0, 16'h84));
    put(32'h110, encI(6'h08, 0, 4, 16'd1));
    put(32'h114, encR(0, 4, 3, 6'h22));
    put(32'h118, encI(6'h2B, 0, 3, 16'h88));
    put(32'h11C, encR(3, 0, 5, 6'h2A));
    put(32'h120, encI(6'h2B, 0, 5, 16'h8C));
    put(32'h124, encI(6'h08, 0, 8, 16'hFFFD));
    put(32'h128, encR(8, 1, 9, 6'h20));
    put(32'h12C, encI(6'h2B, 0, 9, 16'h90));
    put(32'h130, encJ(32'h10));
    put(32'h010, encI(6'h04, 1, 1, 16'hFFFF));
    releaseRst();
    waitLoop("p1_loop");
    check("p1_first_fetch", logAddr[0], RST_PC);
    check("p1_addi_lat", lat(32'h100), 4);
    check("p1_sw_lat", lat(32'h104), 4);
    check("p1_r_lat", lat(32'h108), 4);
    check("p1_j_lat", lat(32'h130), 3);
    check("p1_beq_lat", lat(32'h10), 3);
    check("p1_r1", mem[32'h80 >> 2], 32'd5);
    check("p1_r0", mem[32'h84 >> 2], 32'd0);
    check("p1_sub", mem[32'h88 >> 2], 32'hFFFF_FFFF);
    check("p1_slt", mem[32'h8C >> 2], 32'd1);
    check("p1_negimm", mem[32'h90 >> 2], 32'd2);

    // lw/sw with three wait states per access
    startPhase(3);
    put(32'h004, 32'hDEAD_BEEF);
    put(32'h100, encI(6'h23, 0, 2, 16'h4));
    put(32'h104, encI(6'h2B, 0, 2, 16'h8));
    put(32'h108, encJ(32'h10));
    put(32'h010, encI(6'h04, 1, 1, 16'hFFFF));
    releaseRst();
    waitLoop("p2_loop");
    check("p2_mem8", mem[2], 32'hDEAD_BEEF);
    check("p2_lw_lat", lat(32'h100), 11);
    check("p2_sw_lat", lat(32'h104), 10);

    // irq during a lw read wait, held high through the handler
    startPhase(3);
    put(32'h004, 32'h1234_5678);
    put(32'h100, encJ(32'h20));
    put(32'h020, encI(6'h23, 0, 9, 16'h4));
    put(32'h024, encI(6'h2B, 0, 9, 16'hC));
    put(32'h028, encJ(32'h10));
    put(32'h010, encI(6'h04, 1, 1, 16'hFFFF));
    put(VEC, {6'h10, 20'h0, 6'h18});
    irqAt.push_back(32'h24);
    irqAt.push_back(32'h24);
    releaseRst();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(memReq && !memWe && memAddr == 32'h4 && !memReady) && n < 200);
    check("p3_memrd_wait_seen", {31'h0, n < 200}, 32'h1);
    @(posedge clk); #1 irq = 1'b1;
    n = 0;
    while (actAck < 2 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 irq = 1'b0;
    waitLoop("p3_loop");
    check("p3_ack_count", actAck, 2);
    check("p3_ack_model", actAck, expAck);
    check("p3_vector", fetchAfter(32'h20, 1), VEC);
    check("p3_return", fetchAfter(32'h20, 3), 32'h24);
    check("p3_mem", mem[3], 32'h1234_5678);

    // undefined opcode and undefined R-type funct
    startPhase(0);
    put(32'h100, encJ(32'h40));
    put(32'h040, 32'hFC00_0000);
    put(32'h044, encR(1, 1, 1, 6'h3F));
    put(32'h048, encI(6'h2B, 0, 1, 16'h94));
    put(32'h04C, encJ(32'h10));
    put(32'h010, encI(6'h04, 1, 1, 16'hFFFF));
    releaseRst();
    waitLoop("p4_loop");
    check("p4_ill_count", actIll, 2);
    check("p4_ill_model", actIll, expIll);
    check("p4_next_fetch", fetchAfter(32'h40, 1), 32'h44);
    check("p4_r1_kept", mem[32'h94 >> 2], 32'd5);

    // reset during a store wait
    startPhase(3);
    put(32'h100, encI(6'h2B, 0, 1, 16'h98));
    put(32'h104, encJ(32'h10));
    put(32'h010, encI(6'h04, 1, 1, 16'hFFFF));
    releaseRst();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(memReq && memWe && !memReady) && n < 200);
    check("p5_memwr_seen", {31'h0, n < 200}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("p5_store_dropped", mem[32'h98 >> 2], 32'h0);
    releaseRst();
    waitLoop("p5_loop");
    check("p5_store_redone", mem[32'h98 >> 2], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
